// File: rtl/level_sequencer_if.sv
// Game-flow signal bundle for level_sequencer: gameplay status in, state flags,
// respawn pulse and death counter out.
interface level_sequencer_if;
  logic [7:0]  keycode [6];
  logic        player_hit;
  logic        goal_reached;
  logic        coins_done;

  logic        Title_Screen;
  logic        Wait_Before_Level1;
  logic        Wait_Before_Level2;
  logic        Wait_Before_Level3;
  logic        Level1_Active;
  logic        Level2_Active;
  logic        Level3_Active;
  logic        Wait_State1;
  logic        Wait_State2;
  logic        Win_Screen;
  logic        Reset;
  logic [15:0] death_count;

  modport master (
    output keycode, player_hit, goal_reached, coins_done,
    input  Title_Screen, Wait_Before_Level1, Wait_Before_Level2, Wait_Before_Level3,
    input  Level1_Active, Level2_Active, Level3_Active,
    input  Wait_State1, Wait_State2, Win_Screen, Reset, death_count
  );

  modport slave (
    input  keycode, player_hit, goal_reached, coins_done,
    output Title_Screen, Wait_Before_Level1, Wait_Before_Level2, Wait_Before_Level3,
    output Level1_Active, Level2_Active, Level3_Active,
    output Wait_State1, Wait_State2, Win_Screen, Reset, death_count
  );
endinterface

// File: rtl/level_sequencer.sv
// Three-level game flow FSM clocked once per video frame.
// Define DEATH_COUNT_EN to build the saturating death counter; otherwise death_count is 0.
module level_sequencer #(
  parameter int WAIT_FRAMES   = 60,
  parameter int BANNER_FRAMES = 120
) (
  input logic               frame_clk,
  input logic               Reset_n,
  level_sequencer_if.slave  bus
);

  typedef enum logic [3:0] {
    TITLE, WBL1, L1, WS1, WBL2, L2, WS2, WBL3, L3, WIN
  } state_t;

  localparam int MAX_FRAMES = (WAIT_FRAMES > BANNER_FRAMES) ? WAIT_FRAMES : BANNER_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(WAIT_FRAMES - 1);
  localparam logic [CNT_W-1:0] BANNER_LAST = CNT_W'(BANNER_FRAMES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             start, start_prev, start_rise;
  logic             hit, reset_q;

  always_comb begin
    start = 1'b0;
    for (int i = 0; i < 6; i++)
      if (bus.keycode[i] == 8'h28) start = 1'b1;
  end

  // Leaving TITLE needs a fresh press, so a key held from WIN or through reset is ignored.
  assign start_rise = start & ~start_prev;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    hit        = 1'b0;
    unique case (state)
      TITLE: if (start_rise) state_next = WBL1;
      WBL1:  if (cnt == WAIT_LAST)   state_next = L1;   else cnt_next = cnt + CNT_W'(1);
      WBL2:  if (cnt == WAIT_LAST)   state_next = L2;   else cnt_next = cnt + CNT_W'(1);
      WBL3:  if (cnt == WAIT_LAST)   state_next = L3;   else cnt_next = cnt + CNT_W'(1);
      WS1:   if (cnt == BANNER_LAST) state_next = WBL2; else cnt_next = cnt + CNT_W'(1);
      WS2:   if (cnt == BANNER_LAST) state_next = WBL3; else cnt_next = cnt + CNT_W'(1);
      L1, L2, L3: begin
        // A hit outranks level completion in the same frame.
        if (bus.player_hit) hit = 1'b1;
        else if (bus.goal_reached && bus.coins_done)
          state_next = (state == L1) ? WS1 : (state == L2) ? WS2 : WIN;
      end
      WIN:     if (start) state_next = TITLE;
      default: state_next = TITLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= TITLE;
      cnt        <= '0;
      start_prev <= 1'b1;
      reset_q    <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      start_prev <= start;
      reset_q    <= hit;
    end
  end

`ifdef DEATH_COUNT_EN
  logic [15:0] death_q;
  logic        clear_deaths;

  assign clear_deaths = (state == TITLE) && start_rise;

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n)                           death_q <= '0;
    else if (clear_deaths)                  death_q <= '0;
    else if (hit && death_q != 16'hFFFF)    death_q <= death_q + 16'd1;
  end

  assign bus.death_count = death_q;
`else
  assign bus.death_count = 16'd0;
`endif

  assign bus.Reset              = reset_q;
  assign bus.Title_Screen       = (state == TITLE);
  assign bus.Wait_Before_Level1 = (state == WBL1);
  assign bus.Level1_Active      = (state == L1);
  assign bus.Wait_State1        = (state == WS1);
  assign bus.Wait_Before_Level2 = (state == WBL2);
  assign bus.Level2_Active      = (state == L2);
  assign bus.Wait_State2        = (state == WS2);
  assign bus.Wait_Before_Level3 = (state == WBL3);
  assign bus.Level3_Active      = (state == L3);
  assign bus.Win_Screen         = (state == WIN);

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer: full game walk-through, hit priority,
// restart edge detection and asynchronous reset.
module tb_level_sequencer;

  logic frame_clk = 1'b0;
  logic Reset_n;
  always #5 frame_clk = ~frame_clk;

  level_sequencer_if bus ();

  level_sequencer #(.WAIT_FRAMES(60), .BANNER_FRAMES(120)) dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (bus)
  );

`ifdef DEATH_COUNT_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  // Flag order: Title, WBL1, L1, WS1, WBL2, L2, WS2, WBL3, L3, Win.
  localparam logic [9:0] F_TITLE = 10'b10_0000_0000;
  localparam logic [9:0] F_WBL1  = 10'b01_0000_0000;
  localparam logic [9:0] F_L1    = 10'b00_1000_0000;
  localparam logic [9:0] F_WS1   = 10'b00_0100_0000;
  localparam logic [9:0] F_WBL2  = 10'b00_0010_0000;
  localparam logic [9:0] F_L2    = 10'b00_0001_0000;
  localparam logic [9:0] F_WS2   = 10'b00_0000_1000;
  localparam logic [9:0] F_WBL3  = 10'b00_0000_0100;
  localparam logic [9:0] F_L3    = 10'b00_0000_0010;
  localparam logic [9:0] F_WIN   = 10'b00_0000_0001;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [9:0] flags();
    return {bus.Title_Screen, bus.Wait_Before_Level1, bus.Level1_Active, bus.Wait_State1,
            bus.Wait_Before_Level2, bus.Level2_Active, bus.Wait_State2,
            bus.Wait_Before_Level3, bus.Level3_Active, bus.Win_Screen};
  endfunction

  function automatic logic [15:0] exp_deaths(int n);
    return DC_EN ? 16'(n) : 16'd0;
  endfunction

  task automatic tick();
    @(negedge frame_clk);
  endtask

  task automatic ticks(int n);
    repeat (n) @(negedge frame_clk);
  endtask

  task automatic set_enter(bit on);
    bus.keycode[3] = on ? 8'h28 : 8'h00;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 6; i++) bus.keycode[i] = 8'h00;
    bus.player_hit   = 1'b0;
    bus.goal_reached = 1'b0;
    bus.coins_done   = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    clear_inputs();
    #2;
    n_checks++;
    if (flags() !== F_TITLE || bus.Reset !== 1'b0 || bus.death_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: flags=%b Reset=%b deaths=%0d, expected flags=%b Reset=0 deaths=0",
               flags(), bus.Reset, bus.death_count, F_TITLE);
    end
    ticks(2);
    Reset_n = 1'b1;
    bus.keycode[0] = 8'h2C;
    ticks(4);
    n_checks++;
    if (flags() !== F_TITLE) begin
      n_fail++;
      $display("FAIL non_enter_key: flags=%b expected %b", flags(), F_TITLE);
    end
    bus.keycode[0] = 8'h00;
  endtask

  task automatic test_start();
    set_enter(1'b1);
    tick();
    n_checks++;
    if (flags() !== F_WBL1 || bus.death_count !== 16'd0) begin
      n_fail++;
      $display("FAIL start_wbl1: flags=%b deaths=%0d, expected flags=%b deaths=0",
               flags(), bus.death_count, F_WBL1);
    end
    set_enter(1'b0);
    ticks(59);
    n_checks++;
    if (flags() !== F_WBL1) begin
      n_fail++;
      $display("FAIL wbl1_last_frame: flags=%b expected %b", flags(), F_WBL1);
    end
    tick();
    n_checks++;
    if (flags() !== F_L1) begin
      n_fail++;
      $display("FAIL enter_l1: flags=%b expected %b", flags(), F_L1);
    end
  endtask

  task automatic test_level1_complete();
    bus.goal_reached = 1'b1;
    bus.coins_done   = 1'b0;
    ticks(10);
    n_checks++;
    if (flags() !== F_L1 || bus.Reset !== 1'b0) begin
      n_fail++;
      $display("FAIL goal_without_coins: flags=%b Reset=%b, expected flags=%b Reset=0",
               flags(), bus.Reset, F_L1);
    end
    bus.coins_done = 1'b1;
    tick();
    n_checks++;
    if (flags() !== F_WS1) begin
      n_fail++;
      $display("FAIL enter_ws1: flags=%b expected %b", flags(), F_WS1);
    end
    bus.goal_reached = 1'b0;
    bus.coins_done   = 1'b0;
    bus.player_hit   = 1'b1;
    ticks(119);
    n_checks++;
    if (flags() !== F_WS1 || bus.Reset !== 1'b0 || bus.death_count !== 16'd0) begin
      n_fail++;
      $display("FAIL ws1_hit_ignored: flags=%b Reset=%b deaths=%0d, expected flags=%b Reset=0 deaths=0",
               flags(), bus.Reset, bus.death_count, F_WS1);
    end
    tick();
    n_checks++;
    if (flags() !== F_WBL2 || bus.Reset !== 1'b0) begin
      n_fail++;
      $display("FAIL enter_wbl2: flags=%b Reset=%b, expected flags=%b Reset=0",
               flags(), bus.Reset, F_WBL2);
    end
    bus.player_hit = 1'b0;
    ticks(60);
    n_checks++;
    if (flags() !== F_L2) begin
      n_fail++;
      $display("FAIL enter_l2: flags=%b expected %b", flags(), F_L2);
    end
  endtask

  task automatic test_hits();
    for (int k = 1; k <= 3; k++) begin
      bus.player_hit = 1'b1;
      tick();
      n_checks++;
      if (flags() !== F_L2 || bus.Reset !== 1'b1 || bus.death_count !== exp_deaths(k)) begin
        n_fail++;
        $display("FAIL hit_%0d: flags=%b Reset=%b deaths=%0d, expected flags=%b Reset=1 deaths=%0d",
                 k, flags(), bus.Reset, bus.death_count, F_L2, exp_deaths(k));
      end
    end
    bus.player_hit = 1'b0;
    tick();
    n_checks++;
    if (flags() !== F_L2 || bus.Reset !== 1'b0 || bus.death_count !== exp_deaths(3)) begin
      n_fail++;
      $display("FAIL hit_release: flags=%b Reset=%b deaths=%0d, expected flags=%b Reset=0 deaths=%0d",
               flags(), bus.Reset, bus.death_count, F_L2, exp_deaths(3));
    end
    bus.goal_reached = 1'b1;
    bus.coins_done   = 1'b1;
    tick();
    n_checks++;
    if (flags() !== F_WS2) begin
      n_fail++;
      $display("FAIL enter_ws2: flags=%b expected %b", flags(), F_WS2);
    end
    bus.goal_reached = 1'b0;
    bus.coins_done   = 1'b0;
    ticks(120);
    n_checks++;
    if (flags() !== F_WBL3) begin
      n_fail++;
      $display("FAIL enter_wbl3: flags=%b expected %b", flags(), F_WBL3);
    end
    ticks(60);
    n_checks++;
    if (flags() !== F_L3) begin
      n_fail++;
      $display("FAIL enter_l3: flags=%b expected %b", flags(), F_L3);
    end
  endtask

  task automatic test_hit_vs_goal();
    bus.player_hit   = 1'b1;
    bus.goal_reached = 1'b1;
    bus.coins_done   = 1'b1;
    tick();
    n_checks++;
    if (flags() !== F_L3 || bus.Reset !== 1'b1 || bus.death_count !== exp_deaths(4)) begin
      n_fail++;
      $display("FAIL hit_beats_goal: flags=%b Reset=%b deaths=%0d, expected flags=%b Reset=1 deaths=%0d",
               flags(), bus.Reset, bus.death_count, F_L3, exp_deaths(4));
    end
    bus.player_hit = 1'b0;
    tick();
    n_checks++;
    if (flags() !== F_WIN || bus.Reset !== 1'b0 || bus.death_count !== exp_deaths(4)) begin
      n_fail++;
      $display("FAIL enter_win: flags=%b Reset=%b deaths=%0d, expected flags=%b Reset=0 deaths=%0d",
               flags(), bus.Reset, bus.death_count, F_WIN, exp_deaths(4));
    end
    bus.goal_reached = 1'b0;
    bus.coins_done   = 1'b0;
  endtask

  task automatic test_win_restart();
    set_enter(1'b1);
    tick();
    n_checks++;
    if (flags() !== F_TITLE) begin
      n_fail++;
      $display("FAIL win_to_title: flags=%b expected %b", flags(), F_TITLE);
    end
    ticks(4);
    n_checks++;
    if (flags() !== F_TITLE || bus.death_count !== exp_deaths(4)) begin
      n_fail++;
      $display("FAIL held_enter_no_skip: flags=%b deaths=%0d, expected flags=%b deaths=%0d",
               flags(), bus.death_count, F_TITLE, exp_deaths(4));
    end
    set_enter(1'b0);
    tick();
    set_enter(1'b1);
    tick();
    n_checks++;
    if (flags() !== F_WBL1 || bus.death_count !== 16'd0) begin
      n_fail++;
      $display("FAIL restart_clears_deaths: flags=%b deaths=%0d, expected flags=%b deaths=0",
               flags(), bus.death_count, F_WBL1);
    end
    set_enter(1'b0);
  endtask

  task automatic test_async_reset();
    ticks(60);
    bus.goal_reached = 1'b1;
    bus.coins_done   = 1'b1;
    tick();
    bus.goal_reached = 1'b0;
    bus.coins_done   = 1'b0;
    ticks(120);
    n_checks++;
    if (flags() !== F_WBL2) begin
      n_fail++;
      $display("FAIL reach_wbl2: flags=%b expected %b", flags(), F_WBL2);
    end
    ticks(30);
    #2 Reset_n = 1'b0;
    #1;
    n_checks++;
    if (flags() !== F_TITLE || bus.Reset !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_wbl2: flags=%b Reset=%b, expected flags=%b Reset=0",
               flags(), bus.Reset, F_TITLE);
    end
    set_enter(1'b1);
    tick();
    Reset_n = 1'b1;
    tick();
    n_checks++;
    if (flags() !== F_TITLE) begin
      n_fail++;
      $display("FAIL held_enter_after_reset: flags=%b expected %b", flags(), F_TITLE);
    end
    set_enter(1'b0);
    tick();
    set_enter(1'b1);
    tick();
    set_enter(1'b0);
    ticks(60);
    n_checks++;
    if (flags() !== F_L1) begin
      n_fail++;
      $display("FAIL rerun_l1: flags=%b expected %b", flags(), F_L1);
    end
    bus.player_hit = 1'b1;
    tick();
    #2 Reset_n = 1'b0;
    #1;
    n_checks++;
    if (flags() !== F_TITLE || bus.Reset !== 1'b0 || bus.death_count !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset_level: flags=%b Reset=%b deaths=%0d, expected flags=%b Reset=0 deaths=0",
               flags(), bus.Reset, bus.death_count, F_TITLE);
    end
    bus.player_hit = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick();
  endtask

`ifdef DEATH_COUNT_EN
  task automatic test_saturation();
    set_enter(1'b1);
    tick();
    set_enter(1'b0);
    ticks(60);
    bus.player_hit = 1'b1;
    ticks(65540);
    n_checks++;
    if (flags() !== F_L1 || bus.death_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL death_saturate: flags=%b deaths=%h, expected flags=%b deaths=ffff",
               flags(), bus.death_count, F_L1);
    end
    bus.player_hit = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_level1_complete();
    test_hits();
    test_hit_vs_goal();
    test_win_restart();
    test_async_reset();
`ifdef DEATH_COUNT_EN
    test_saturation();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
